// File: rtl/rat_io_pkg.sv
// ============================================================================
// rat_io_pkg : shared types and defaults for board I/O conditioning blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package rat_io_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// bit_synchronizer : multi-flop synchronizer for one asynchronous input bit
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer : synchronizes a bouncy push-button and emits a clean level
//                    plus single-cycle rise/fall strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debouncer
  import rat_io_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_raw,
  output logic press,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic            w_smp;
  debounce_state_t r_state;
  logic [CW-1:0]   r_cnt;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (btn_raw),
    .q     (w_smp)
  );

  // Any opposite sample in a WAIT state drops straight back to IDLE: no partial credit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      press   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_smp) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= C_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!w_smp) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            press   <= 1'b1;
            rise    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_smp) begin
            r_state <= WAIT_LOW;
            r_cnt   <= C_ONE;
          end
        end
        WAIT_LOW: begin
          if (w_smp) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            press   <= 1'b0;
            fall    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// tb_button_debouncer : scoreboard bench with a run-length reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic CLK;
  logic RST_N;
  logic btn_raw;
  logic press;
  logic rise;
  logic fall;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];

  button_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .btn_raw (btn_raw),
    .press   (press),
    .rise    (rise),
    .fall    (fall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {press,rise,fall}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: the FSM sees the pin SYNC edges late; a new level is accepted once
  // STABLE consecutive delayed samples all differ from the current level.
  logic m_pipe[SYNC];
  logic m_press;
  logic m_run_val;
  int   m_run_len;

  always @(posedge CLK) begin
    logic s;
    logic [2:0] e;
    e = 3'b000;
    if (!RST_N) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_press   = 1'b0;
      m_run_val = 1'b0;
      m_run_len = 0;
    end else begin
      s = m_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = btn_raw;
      if (s == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = s;
        m_run_len = 1;
      end
      if (m_run_val != m_press && m_run_len >= STABLE) begin
        m_press = m_run_val;
        e[1] = m_run_val;
        e[0] = ~m_run_val;
      end
    end
    e[2] = m_press;
    exp_q.push_back(e);
  end

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 3'bxxx, 3'b000);
    end else begin
      check("cycle", {press, rise, fall}, exp_q.pop_front());
    end
  end

  task automatic drive(input logic b, input int n);
    btn_raw = b;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_N   = 1'b0;
    btn_raw = 1'b1;
    // Held in reset with the button pressed.
    repeat (10) @(negedge CLK);
    // Release reset with button still held.
    RST_N = 1'b1;
    drive(1'b1, 12);
    // Clean release, clean press, release glitch, release.
    drive(1'b0, 12);
    drive(1'b1, 20);
    drive(1'b0, 2);
    drive(1'b1, 10);
    drive(1'b0, 12);
    // Bounce on press.
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 10);

    // Reset mid-WAIT_HIGH (cnt=2 after four edges).
    drive(1'b1, 4);
    RST_N = 1'b0;
    #1;
    check("async_reset_wait", {press, rise, fall}, 3'b000);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b1, 10);
    drive(1'b0, 12);

    // Reset during a rise strobe discards it immediately.
    drive(1'b1, 6);
    check("pre_reset_strobe", {press, rise, fall}, 3'b110);
    RST_N = 1'b0;
    #1;
    check("async_reset_strobe", {press, rise, fall}, 3'b000);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b0, 8);

    // Randomized bouncing with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        RST_N = 1'b0;
        #1;
        check("async_reset_rand", {press, rise, fall}, 3'b000);
        btn_raw = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        RST_N = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    drive(1'b0, 12);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
